// File: rtl/attr_line_emitter.sv
// Serialises one attribute record into an ASCII attribute line such as (* KEY="val" *)\n.
// Optional record checking is enabled with `define ATTR_LINE_EMITTER_CHECK_EN.
module attr_line_emitter #(
  parameter int KEY_CHARS = 8,
  parameter int STR_CHARS = 8,
  parameter int INT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*KEY_CHARS-1:0] in_key,
  input  logic [3:0]             in_key_len,
  input  logic [1:0]             in_kind,
  input  logic [INT_W-1:0]       in_int,
  input  logic [8*STR_CHARS-1:0] in_str,
  input  logic [3:0]             in_str_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic                   err
);

  // Handshakes: a record moves when in_valid && in_ready, a byte moves when
  // out_valid && out_ready; an offered byte is held unchanged until it moves.

  localparam int DIG   = (INT_W * 30103) / 100000 + 1;
  localparam int BCD_W = 4 * DIG;
  localparam int IW    = ($clog2(INT_W) + 1 > 5) ? $clog2(INT_W) + 1 : 5;
  localparam logic [1:0] K_NONE = 2'd0, K_INT = 2'd1, K_STR = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_OPEN, S_KEY, S_EQ, S_CONV, S_DIGITS,
    S_QO, S_STR, S_QC, S_CLOSE, S_NL, S_DROP
  } state_t;

  state_t                 state, state_n, after_key;
  logic [IW-1:0]          idx, idx_n, msd;
  logic                   alive, accept, fire, bad;
  logic [8*KEY_CHARS-1:0] key_sh;
  logic [8*STR_CHARS-1:0] str_sh;
  logic [3:0]             klen, slen, digit;
  logic [1:0]             kind;
  logic [INT_W-1:0]       bin;
  logic [BCD_W-1:0]       bcd, bcd_adj, bcd_n;

  assign in_ready = alive && (state == S_IDLE);
  assign accept   = in_ready && in_valid;
  assign fire     = out_valid && out_ready;

`ifdef ATTR_LINE_EMITTER_CHECK_EN
  assign bad = (in_key_len == 4'd0) || (in_key_len > 4'(KEY_CHARS)) || (in_kind == 2'd3) ||
               ((in_kind == K_STR) && (in_str_len > 4'(STR_CHARS)));
  assign err = (state == S_DROP);
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  assign after_key = ((kind == K_INT) || (kind == K_STR)) ? S_EQ : S_CLOSE;

  // One shift-add-3 step per CONV cycle; msd locates the leading non-zero digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIG; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_n = {bcd_adj[BCD_W-2:0], bin[INT_W-1]};
    msd = '0;
    for (int i = 0; i < DIG; i++)
      if (bcd_n[4*i +: 4] != 4'd0) msd = IW'(i);
    digit = 4'd0;
    for (int i = 0; i < DIG; i++)
      if (idx == IW'(i)) digit = bcd[4*i +: 4];
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        state_n = bad ? S_DROP : S_OPEN;
        idx_n   = '0;
      end
      S_OPEN: begin
        out_valid = 1'b1;
        out_data  = (idx == IW'(0)) ? "(" : (idx == IW'(1)) ? "*" : " ";
        if (fire) begin
          if (idx == IW'(2)) begin
            state_n = (klen != 4'd0) ? S_KEY : after_key;
            idx_n   = IW'(klen);
          end else idx_n = idx + IW'(1);
        end
      end
      S_KEY: begin
        out_valid = 1'b1;
        out_data  = key_sh[8*KEY_CHARS-1 -: 8];
        if (fire) begin
          if (idx == IW'(1)) state_n = after_key;
          idx_n = idx - IW'(1);
        end
      end
      S_EQ: begin
        out_valid = 1'b1;
        out_data  = "=";
        if (fire) begin
          state_n = (kind == K_INT) ? S_CONV : S_QO;
          idx_n   = '0;
        end
      end
      S_CONV: begin
        if (idx == IW'(INT_W - 1)) begin
          state_n = S_DIGITS;
          idx_n   = msd;
        end else idx_n = idx + IW'(1);
      end
      S_DIGITS: begin
        out_valid = 1'b1;
        out_data  = {4'h3, digit};
        if (fire) begin
          if (idx == IW'(0)) state_n = S_CLOSE;
          else idx_n = idx - IW'(1);
        end
      end
      S_QO: begin
        out_valid = 1'b1;
        out_data  = "\"";
        if (fire) begin
          state_n = (slen != 4'd0) ? S_STR : S_QC;
          idx_n   = IW'(slen);
        end
      end
      S_STR: begin
        out_valid = 1'b1;
        out_data  = str_sh[8*STR_CHARS-1 -: 8];
        if (fire) begin
          if (idx == IW'(1)) state_n = S_QC;
          idx_n = idx - IW'(1);
        end
      end
      S_QC: begin
        out_valid = 1'b1;
        out_data  = "\"";
        if (fire) begin
          state_n = S_CLOSE;
          idx_n   = '0;
        end
      end
      S_CLOSE: begin
        out_valid = 1'b1;
        out_data  = (idx == IW'(0)) ? " " : (idx == IW'(1)) ? "*" : ")";
        if (fire) begin
          if (idx == IW'(2)) state_n = S_NL;
          else idx_n = idx + IW'(1);
        end
      end
      S_NL: begin
        out_valid = 1'b1;
        out_data  = 8'h0A;
        out_last  = 1'b1;
        if (fire) state_n = S_IDLE;
      end
      S_DROP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      alive  <= 1'b0;
      key_sh <= '0;
      str_sh <= '0;
      klen   <= 4'd0;
      slen   <= 4'd0;
      kind   <= K_NONE;
      bin    <= '0;
      bcd    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      alive <= 1'b1;
      if (accept) begin
        key_sh <= in_key;
        str_sh <= in_str;
        klen   <= (in_key_len > 4'(KEY_CHARS)) ? 4'(KEY_CHARS) : in_key_len;
        slen   <= (in_str_len > 4'(STR_CHARS)) ? 4'(STR_CHARS) : in_str_len;
        kind   <= (in_kind == 2'd3) ? K_NONE : in_kind;
        bin    <= in_int;
        bcd    <= '0;
      end
      if (state == S_KEY && fire) key_sh <= key_sh << 8;
      if (state == S_STR && fire) str_sh <= str_sh << 8;
      if (state == S_CONV) begin
        bin <= bin << 1;
        bcd <= bcd_n;
      end
    end
  end

endmodule
